// File: rtl/a1_5b_rtl.sv
// a1_5b_rtl: 8:1 single-bit mux leaf cell.
// y_comb is the live select d[s]. y is its enable-gated registered copy.
// chg pulses for one cycle after y changes value.
// par is the registered even parity of d when A1_5B_PARITY_EN is defined.
// Without that macro, par is a constant 0 and there is no parity flop.
module a1_5b_rtl #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] d,
  input  logic [2:0] s,
  output logic       y_comb,
  output logic       y,
  output logic       chg,
  output logic       par
);

  // Even parity of a byte: 1 when an odd number of bits are set.
  function automatic logic even_par(input logic [7:0] v);
    return ^v;
  endfunction

  logic sel_s;
  logic y_r;
  logic chg_r;

  // Live channel select; reset and enable have no effect on this path.
  always_comb begin
    sel_s = 1'b0;
    sel_s = d[s];
  end

  assign y_comb = sel_s;
  assign y      = y_r;
  assign chg    = chg_r;

  // Registered select and change pulse. With en low, y holds and chg drops to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r   <= RST_VAL;
      chg_r <= 1'b0;
    end else if (en) begin
      y_r   <= sel_s;
      chg_r <= (sel_s != y_r);
    end else begin
      y_r   <= y_r;
      chg_r <= 1'b0;
    end
  end

`ifdef A1_5B_PARITY_EN
  logic par_r;

  // Parity of the whole bus, updated only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_r <= 1'b0;
    end else if (en) begin
      par_r <= even_par(d);
    end else begin
      par_r <= par_r;
    end
  end

  assign par = par_r;
`else
  // Keep the helper referenced so the two builds share the same source.
  logic unused_par_s;
  assign unused_par_s = even_par(8'h00);
  assign par = 1'b0;
`endif

endmodule

// File: tb/tb_a1_5b_rtl.sv
// Self-checking bench for a1_5b_rtl.
// It runs directed steps and then random vectors against a behavioural model.
// The model takes bit k of d as (d >> k) & 1 and parity as the population count of d, mod 2.
module tb_a1_5b_rtl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] d;
  logic [2:0] s;
  logic       y_comb;
  logic       y;
  logic       chg;
  logic       par;

  int vectors;
  int miscompares;

  // Reference state.
  logic exp_y;
  logic exp_chg;
  logic exp_par;

  a1_5b_rtl #(.RST_VAL(1'b0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .d      (d),
    .s      (s),
    .y_comb (y_comb),
    .y      (y),
    .chg    (chg),
    .par    (par)
  );

  function automatic logic bit_of(input logic [7:0] v, input int k);
    return (((int'(v) >> k) & 1) != 0);
  endfunction

  function automatic logic parity_of(input logic [7:0] v);
`ifdef A1_5B_PARITY_EN
    return (($countones(v) % 2) == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".y_comb"}, y_comb, bit_of(d, int'(s)));
    chk({tag, ".y"}, y, exp_y);
    chk({tag, ".chg"}, chg, exp_chg);
    chk({tag, ".par"}, par, exp_par);
  endtask

  // One clock period. The model is updated at the rising edge and the outputs are checked 1 time unit later.
  task automatic tick(input string tag);
    logic cur;
    #5 clk = 1'b1;
    cur = bit_of(d, int'(s));
    if (en) begin
      exp_chg = (cur != exp_y);
      exp_y   = cur;
      exp_par = parity_of(d);
    end else begin
      exp_chg = 1'b0;
    end
    #1 chk_all(tag);
    #4 clk = 1'b0;
  endtask

  initial begin
    logic [7:0] sweep;
    logic [7:0] sweep_exp;
    vectors = 0;
    miscompares = 0;
    clk = 1'b0; rst_n = 1'b1; en = 1'b0; d = 8'h00; s = 3'd0;

    // Assert reset with the clock stopped.
    #2 rst_n = 1'b0;
    exp_y = 1'b0; exp_chg = 1'b0; exp_par = 1'b0;
    #1 chk_all("reset");

    // Release the reset. The first enabled edge loads d[3] of 8'hFF.
    #2 rst_n = 1'b1;
    en = 1'b1; d = 8'hFF; s = 3'd3;
    #2 tick("first_edge");
    chk("first_edge.y_is_1", y, 1'b1);
    chk("first_edge.chg_is_1", chg, 1'b1);

    // Combinational sweep with no clock.
    sweep = 8'b1010_0110;
    sweep_exp = 8'b1010_0110;
    d = sweep;
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      #1 chk($sformatf("sweep_s%0d", i), y_comb, sweep_exp[i]);
    end

    // Registered latency: clear y first, then toggle y on back-to-back edges.
    en = 1'b1; d = 8'h00; s = 3'd0;
    tick("clear");
    d = 8'h80; s = 3'd7;
    tick("lat_s7");
    chk("lat_s7.chg_is_1", chg, 1'b1);
    s = 3'd6;
    tick("lat_s6");
    chk("lat_s6.chg_is_1", chg, 1'b1);

    // Hold: set y back to 1, then drop en.
    d = 8'hFF; s = 3'd0;
    tick("set_one");
    en = 1'b0; d = 8'h00; s = 3'd0;
    #1 chk("hold.y_comb_now", y_comb, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick($sformatf("hold%0d", i));
      chk($sformatf("hold%0d.y_still_1", i), y, 1'b1);
    end

    // No change: y is already 1 and every channel of 8'hFF is 1.
    en = 1'b1; d = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      tick($sformatf("nochg_s%0d", i));
    end

    // Parity of 8'h07 and then 8'h03.
    d = 8'h07; s = 3'd1;
    tick("par_07");
    d = 8'h03;
    tick("par_03");

    // Reset asserted mid-operation, between edges.
    d = 8'h02; s = 3'd1;
    tick("pre_rst");
    #2 rst_n = 1'b0;
    exp_y = 1'b0; exp_chg = 1'b0; exp_par = 1'b0;
    #1 chk_all("mid_reset");
    d = 8'h04; s = 3'd2;
    #1 chk("mid_reset.y_comb_tracks", y_comb, 1'b1);
    #1 rst_n = 1'b1;

    // Random vectors; en is high about three times in four.
    for (int i = 0; i < 30; i++) begin
      logic [10:0] v;
      v  = 11'($urandom);
      s  = v[10:8];
      d  = v[7:0];
      en = ($urandom_range(3, 0) != 0);
      #1 chk($sformatf("rnd%0d.y_comb", i), y_comb, bit_of(d, int'(s)));
      tick($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
